// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU operation codes and datapath mux selects.
// Pure declarations; no logic, no latency.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        MULWB  = 4'd9,
        FPEXEC = 4'd10,
        BRANCH = 4'd11,
        UNDEF  = 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_ORR   = 4'b0011;
    localparam logic [3:0] ALU_MUL   = 4'b0100;
    localparam logic [3:0] ALU_UMULL = 4'b0101;
    localparam logic [3:0] ALU_SMULL = 4'b0110;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_FPU       = 2'b11;

    localparam logic [1:0] SRCA_REG  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    // Multiply encodings hide inside the data-processing space: register form with 1001 in bits 7:4.
    function automatic logic is_mul_pattern(input logic [5:0] funct, input logic [3:0] instr_7_4);
        return !funct[5] && (instr_7_4 == 4'b1001);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation and flag-write decode for data-processing and multiply instructions.
// Zero latency; no flow control.
module alu_decoder
    import arm_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    input  logic [2:0] i_instr_23_21,
    input  logic [3:0] i_instr_7_4,
    input  logic       i_alu_op,
    output logic [3:0] o_alu_control,
    output logic [1:0] o_flag_w
);

    logic w_mul;
    logic w_cmp;
    logic w_arith;
    logic w_unused;

    assign w_unused = i_instr_23_21[0];

    always_comb begin
        w_mul         = is_mul_pattern(i_funct, i_instr_7_4);
        w_cmp         = (i_funct[4:1] == 4'b1010);
        w_arith       = !w_mul && ((i_funct[4:1] == 4'b0100) || (i_funct[4:1] == 4'b0010) || w_cmp);
        o_alu_control = ALU_ADD;
        o_flag_w      = 2'b00;
        if (i_alu_op) begin
            // A multiply pattern overrides whatever command the Funct bits would otherwise spell.
            if (w_mul) begin
                if (i_instr_23_21[2]) o_alu_control = i_instr_23_21[1] ? ALU_SMULL : ALU_UMULL;
                else                  o_alu_control = ALU_MUL;
            end else begin
                case (i_funct[4:1])
                    4'b0100: o_alu_control = ALU_ADD;
                    4'b0010: o_alu_control = ALU_SUB;
                    4'b1010: o_alu_control = ALU_SUB;
                    4'b1100: o_alu_control = ALU_ORR;
                    4'b0000: o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            o_flag_w[1] = i_funct[0] | w_cmp;
            o_flag_w[0] = o_flag_w[1] & w_arith;
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle fetch/decode/execute/writeback sequencer driving every datapath control; 3-5 cycles per instruction.
// No backpressure: one state per clock, write enables gated by CondEx and forced low during reset.
module mc_control_fsm
    import arm_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        CondEx,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        RegWrite2,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        Half,
    output logic [1:0]  FlagW,
    output logic [3:0]  State
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic       w_mul;
    logic       w_next_pc, w_branch, w_reg_w, w_reg_w2, w_mem_w, w_ir_w;
    logic       w_adr_src, w_alu_op, w_half, w_mul_hold;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_result_src, w_flag_w;
    logic [3:0] w_dec_alu_control, w_alu_control;
    logic       w_unused_instr;

    assign w_op           = Instr[27:26];
    assign w_funct        = Instr[25:20];
    assign w_rd           = Instr[15:12];
    assign w_mul          = (w_op == 2'b00) && is_mul_pattern(w_funct, Instr[7:4]);
    assign w_unused_instr = ^{Instr[31:28], Instr[19:16], Instr[11:8], Instr[3:0]};

    alu_decoder u_alu_decoder (
        .i_funct       (w_funct),
        .i_instr_23_21 (Instr[23:21]),
        .i_instr_7_4   (Instr[7:4]),
        .i_alu_op      (w_alu_op),
        .o_alu_control (w_dec_alu_control),
        .o_flag_w      (w_flag_w)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= RESET_STATE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = FETCH;
        w_next_pc    = 1'b0;
        w_branch     = 1'b0;
        w_reg_w      = 1'b0;
        w_reg_w2     = 1'b0;
        w_mem_w      = 1'b0;
        w_ir_w       = 1'b0;
        w_adr_src    = ADR_PC;
        w_alu_op     = 1'b0;
        w_half       = 1'b0;
        w_mul_hold   = 1'b0;
        w_alu_src_a  = SRCA_REG;
        w_alu_src_b  = SRCB_REG;
        w_result_src = RES_ALUOUT;
        case (r_state)
            FETCH: begin
                w_ir_w       = 1'b1;
                w_next_pc    = 1'b1;
                w_alu_src_a  = SRCA_PC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_next       = DECODE;
            end
            DECODE: begin
                w_alu_src_a  = SRCA_PC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                case (w_op)
                    2'b01:   w_next = MEMADR;
                    2'b10:   w_next = BRANCH;
                    2'b11:   w_next = FPEXEC;
                    default: begin
                        if (w_funct[5])                        w_next = EXECI;
                        else if (w_mul && Instr[22:21] == 2'b11) w_next = UNDEF;
                        else                                   w_next = EXECR;
                    end
                endcase
            end
            MEMADR: begin
                w_alu_src_b = SRCB_IMM;
                w_next      = w_funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                w_adr_src = ADR_RESULT;
                w_next    = MEMWB;
            end
            MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_w      = 1'b1;
            end
            MEMWR: begin
                w_adr_src = ADR_RESULT;
                w_mem_w   = 1'b1;
            end
            EXECR, EXECI: begin
                w_alu_src_b = (r_state == EXECI) ? SRCB_IMM : SRCB_REG;
                w_alu_op    = 1'b1;
                w_next      = (w_mul && Instr[23]) ? MULWB : ALUWB;
            end
            ALUWB: w_reg_w = (w_funct[4:1] != 4'b1010);
            MULWB: begin
                w_reg_w    = 1'b1;
                w_reg_w2   = 1'b1;
                w_mul_hold = 1'b1;
            end
            FPEXEC: begin
                w_result_src = RES_FPU;
                w_half       = Instr[22];
                w_reg_w      = 1'b1;
            end
            BRANCH: begin
                w_alu_src_b  = SRCB_IMM;
                w_result_src = RES_ALURESULT;
                w_branch     = 1'b1;
            end
            default: w_next = FETCH;
        endcase
    end

    // The 64-bit product needs the multiplier opcode held through the second writeback cycle.
    assign w_alu_control = w_mul_hold ? (Instr[22] ? ALU_SMULL : ALU_UMULL) : w_dec_alu_control;

    always_comb begin
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegWrite2  = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = 4'b0000;
        Half       = 1'b0;
        FlagW      = 2'b00;
        State      = 4'd0;
        if (!reset) begin
            PCWrite    = w_next_pc | (w_branch & CondEx) | (w_reg_w & CondEx & (w_rd == 4'd15));
            RegWrite   = w_reg_w & CondEx;
            RegWrite2  = w_reg_w2 & CondEx;
            MemWrite   = w_mem_w & CondEx;
            IRWrite    = w_ir_w;
            AdrSrc     = w_adr_src;
            RegSrc     = {(w_op == 2'b01) && !w_funct[0], (w_op == 2'b10)};
            ALUSrcA    = w_alu_src_a;
            ALUSrcB    = w_alu_src_b;
            ResultSrc  = w_result_src;
            ImmSrc     = w_op;
            ALUControl = w_alu_control;
            Half       = w_half;
            FlagW      = w_flag_w;
            State      = r_state;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomised and directed instruction streams checked every cycle against an instruction-level control model.
module tb_mc_control_fsm;
    import arm_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        CondEx;
    logic        PCWrite, RegWrite, RegWrite2, MemWrite, IRWrite, AdrSrc, Half;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, FlagW;
    logic [3:0]  ALUControl, State;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, rw, rw2, mw, irw, adr;
        logic [1:0] regsrc, srca, srcb, res, imm;
        logic [3:0] alu;
        logic       half;
        logic [1:0] flagw;
    } ctl_t;

    ctl_t   exp_c;
    ctl_t   hist[$];
    state_t path_q[$];
    logic   chk = 1'b0;
    int     n_tests = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.RESET_STATE(FETCH)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .CondEx(CondEx),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .RegWrite2(RegWrite2), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Half(Half),
        .FlagW(FlagW), .State(State)
    );

    function automatic ctl_t dut_now();
        ctl_t a;
        a.st = State; a.pcw = PCWrite; a.rw = RegWrite; a.rw2 = RegWrite2; a.mw = MemWrite;
        a.irw = IRWrite; a.adr = AdrSrc; a.regsrc = RegSrc; a.srca = ALUSrcA; a.srcb = ALUSrcB;
        a.res = ResultSrc; a.imm = ImmSrc; a.alu = ALUControl; a.half = Half; a.flagw = FlagW;
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Sequence of steps an instruction walks, straight from the opcode rules.
    task automatic build_path(input logic [31:0] ins);
        logic [1:0] op;
        logic [5:0] fn;
        logic       mulp;
        op   = ins[27:26];
        fn   = ins[25:20];
        mulp = (op == 2'b00) && !fn[5] && (ins[7:4] == 4'b1001);
        path_q = {FETCH, DECODE};
        case (op)
            2'b01: begin
                path_q.push_back(MEMADR);
                if (fn[0]) begin path_q.push_back(MEMRD); path_q.push_back(MEMWB); end
                else       path_q.push_back(MEMWR);
            end
            2'b10: path_q.push_back(BRANCH);
            2'b11: path_q.push_back(FPEXEC);
            default: begin
                if (mulp && ins[22:21] == 2'b11) path_q.push_back(UNDEF);
                else begin
                    path_q.push_back(fn[5] ? EXECI : EXECR);
                    path_q.push_back((mulp && ins[23]) ? MULWB : ALUWB);
                end
            end
        endcase
    endtask

    function automatic ctl_t model(state_t s, logic [31:0] ins, logic cx);
        ctl_t       e;
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] cmd;
        logic       mulp, is_cmp, is_arith, next_pc, branch, regw, regw2, memw, alu_op;
        op = ins[27:26]; fn = ins[25:20]; cmd = fn[4:1];
        mulp   = (op == 2'b00) && !fn[5] && (ins[7:4] == 4'b1001);
        is_cmp = (cmd == 4'b1010);
        e = '0;
        next_pc = 0; branch = 0; regw = 0; regw2 = 0; memw = 0; alu_op = 0;
        e.st     = s;
        e.regsrc = {(op == 2'b01) && !fn[0], op == 2'b10};
        e.imm    = op;
        e.alu    = ALU_ADD;
        case (s)
            FETCH:  begin e.irw = 1; e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; next_pc = 1; end
            DECODE: begin e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; end
            MEMADR: e.srcb = 2'b01;
            MEMRD:  e.adr = 1;
            MEMWB:  begin e.res = 2'b01; regw = 1; end
            MEMWR:  begin e.adr = 1; memw = 1; end
            EXECR:  alu_op = 1;
            EXECI:  begin e.srcb = 2'b01; alu_op = 1; end
            ALUWB:  regw = !is_cmp;
            MULWB:  begin regw = 1; regw2 = 1; e.alu = ins[22] ? ALU_SMULL : ALU_UMULL; end
            FPEXEC: begin e.res = 2'b11; e.half = ins[22]; regw = 1; end
            BRANCH: begin e.srcb = 2'b01; e.res = 2'b10; branch = 1; end
            default: ;
        endcase
        if (alu_op) begin
            if (mulp)                                   e.alu = !ins[23] ? ALU_MUL : (ins[22] ? ALU_SMULL : ALU_UMULL);
            else if (cmd == 4'b0100)                    e.alu = ALU_ADD;
            else if (cmd == 4'b0010 || is_cmp)          e.alu = ALU_SUB;
            else if (cmd == 4'b1100)                    e.alu = ALU_ORR;
            else if (cmd == 4'b0000)                    e.alu = ALU_AND;
            else                                        e.alu = ALU_ADD;
            is_arith   = !mulp && (cmd == 4'b0100 || cmd == 4'b0010 || is_cmp);
            e.flagw[1] = fn[0] | is_cmp;
            e.flagw[0] = e.flagw[1] & is_arith;
        end
        e.pcw = next_pc | (branch & cx) | (regw & cx & (ins[15:12] == 4'hF));
        e.rw  = regw & cx;
        e.rw2 = regw2 & cx;
        e.mw  = memw & cx;
        return e;
    endfunction

    always @(negedge clk) begin
        ctl_t a;
        if (chk) begin
            a = dut_now();
            check("state", 32'(a.st), 32'(exp_c.st));
            check("enables", 32'({a.pcw, a.rw, a.rw2, a.mw, a.irw}),
                             32'({exp_c.pcw, exp_c.rw, exp_c.rw2, exp_c.mw, exp_c.irw}));
            check("mux_selects", 32'({a.adr, a.regsrc, a.srca, a.srcb, a.res, a.imm, a.half}),
                                 32'({exp_c.adr, exp_c.regsrc, exp_c.srca, exp_c.srcb, exp_c.res, exp_c.imm, exp_c.half}));
            check("alu_flags", 32'({a.alu, a.flagw}), 32'({exp_c.alu, exp_c.flagw}));
        end
    end

    task automatic drive(input logic rst, input logic [31:0] ins, input logic cx, input state_t s);
        @(posedge clk);
        #1;
        reset  = rst;
        Instr  = ins;
        CondEx = cx;
        exp_c  = rst ? '0 : model(s, ins, cx);
        chk    = 1'b1;
        @(negedge clk);
        hist.push_back(dut_now());
    endtask

    // mode 0/1: CondEx held at that value; mode 2: CondEx random each cycle.
    task automatic run_instr(input logic [31:0] ins, input int mode, input int nmax);
        logic cx;
        build_path(ins);
        hist.delete();
        for (int i = 0; i < path_q.size() && i < nmax; i++) begin
            cx = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
            drive(1'b0, ins, cx, path_q[i]);
        end
    endtask

    initial begin
        logic [31:0] ins;
        reset = 1'b1; Instr = 32'h0; CondEx = 1'b0;
        drive(1'b1, 32'h0, 1'b0, FETCH);
        drive(1'b1, 32'h0, 1'b1, FETCH);

        run_instr(32'hE5912004, 1, 99);
        check("ldr_memrd_adrsrc", 32'(hist[3].adr), 1);
        check("ldr_memrd_regwrite", 32'(hist[3].rw), 0);
        check("ldr_memwb_state", 32'(hist[4].st), 32'(MEMWB));
        check("ldr_memwb_regwrite", 32'(hist[4].rw), 1);
        check("ldr_memwb_resultsrc", 32'(hist[4].res), 1);

        run_instr(32'hE0810392, 1, 99);
        check("umull_execr_alu", 32'(hist[2].alu), 5);
        check("umull_mulwb_state", 32'(hist[3].st), 32'(MULWB));
        check("umull_mulwb_alu", 32'(hist[3].alu), 5);
        check("umull_mulwb_rw_rw2", 32'({hist[3].rw, hist[3].rw2}), 3);

        run_instr(32'hE0512003, 1, 99);
        check("after_umull_fetch", 32'(hist[0].st), 32'(FETCH));
        check("subs_execr_flagw", 32'(hist[2].flagw), 3);
        check("subs_aluwb_regwrite", 32'(hist[3].rw), 1);
        run_instr(32'hE0512003, 0, 99);
        check("subs_nocond_state", 32'(hist[3].st), 32'(ALUWB));
        check("subs_nocond_regwrite", 32'(hist[3].rw), 0);

        run_instr(32'hEE600000, 1, 99);
        check("fp_state", 32'(hist[2].st), 32'(FPEXEC));
        check("fp_res_half_rw", 32'({hist[2].res, hist[2].half, hist[2].rw}), 32'b1111);

        run_instr(32'h0A000002, 1, 99);
        check("after_fp_fetch", 32'(hist[0].st), 32'(FETCH));
        check("beq_taken_pcwrite", 32'(hist[2].pcw), 1);
        check("beq_regsrc", 32'(hist[2].regsrc), 1);
        run_instr(32'h0A000002, 0, 99);
        check("beq_nottaken_pcwrite", 32'(hist[2].pcw), 0);

        // Store interrupted by a three-cycle reset while in MEMWR.
        run_instr(32'hE5812004, 1, 3);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hE5812004, 1'b1, FETCH);
        check("rst_memwrite", 32'({hist[3].mw, hist[4].mw, hist[5].mw}), 0);
        run_instr(32'hE5912004, 1, 99);
        check("rst_release_irw_pcw", 32'({hist[0].irw, hist[0].pcw}), 3);

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: begin ins[27:25] = 3'b000; ins[7:4] = 4'b1001; end
                1: ins[15:12] = 4'hF;
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                run_instr(ins, 2, $urandom_range(1, 4));
                drive(1'b1, ins, 1'($urandom_range(0, 1)), FETCH);
            end else begin
                run_instr(ins, 2, 99);
            end
        end

        @(posedge clk);
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit sitting directly upstream of the datapath.
- Consumes the registered instruction word and the condition-pass bit from condlogic.
- Sequences fetch/decode/execute/writeback and drives every datapath control input.
- Covers load/store, data-processing, long multiply (dual register write) and single/half-precision FP ops.

Parameters:
- RESET_STATE, FETCH: state entered on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Instr  in  32  instruction register contents (datapath Instr)
- CondEx  in  1  condition passed for the current instruction (registered by condlogic)
- PCWrite  out  1  PC register enable
- RegWrite  out  1  regfile port-3 write enable
- RegWrite2  out  1  regfile port-4 write enable (high word of long multiply)
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  0 = PC, 1 = Result
- RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Rd
- ALUSrcA  out  2  00 = A, 01 = PC
- ALUSrcB  out  2  00 = reg, 01 = ExtImm, 10 = 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = FPUResult
- ImmSrc  out  2  equals Op
- ALUControl  out  4  ALU operation code
- Half  out  1  selects FP16 result
- FlagW  out  2  flag-write enables to condlogic
- State  out  4  current state, for verification

Behaviour:
- Fields: Op = Instr[27:26]; Funct = Instr[25:20]; Rd = Instr[15:12].
- MUL pattern: Op = 00, Funct[5] = 0, Instr[7:4] = 1001.
  - Instr[23] = 1 → long multiply. Instr[22] = 0 → UMULL, 1 → SMULL.
  - Instr[23] = 0 → MUL.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, MULWB, FPEXEC, BRANCH, UNDEF.
- Reset: state = FETCH on the next edge, including mid-instruction. While reset is high, every enable (PCWrite, RegWrite, RegWrite2, MemWrite, IRWrite) is 0 and all other outputs are 0.
- FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 01, ALUSrcB = 10, ALU = ADD, ResultSrc = 10, NextPC = 1. → DECODE.
- DECODE: ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10, no writes. Next state:
  - Op = 01 → MEMADR
  - Op = 10 → BRANCH
  - Op = 11 → FPEXEC
  - Op = 00 with Funct[5] = 1 → EXECI
  - Op = 00, MUL pattern with Instr[22:21] ≠ 11 → EXECR
  - other Op = 00 → EXECR
  - Op = 00, MUL pattern with Instr[22:21] = 11 → UNDEF
- MEMADR: ALUSrcA = 00, ALUSrcB = 01, ADD. Funct[0] = 1 → MEMRD, else → MEMWR.
- MEMRD: AdrSrc = 1, ResultSrc = 00. → MEMWB.
- MEMWB: ResultSrc = 01, RegW. → FETCH.
- MEMWR: AdrSrc = 1, ResultSrc = 00, MemW. → FETCH.
- EXECR / EXECI: ALUSrcA = 00; ALUSrcB = 00 (R) or 01 (I); ALUOp = 1. Long multiply → MULWB, else → ALUWB.
- ALUWB: ResultSrc = 00, RegW unless the command is CMP (Funct[4:1] = 1010). → FETCH.
- MULWB: ResultSrc = 00, RegW and RegW2; ALUControl held at UMULL/SMULL. → FETCH.
- FPEXEC: ALUSrcA = 00, ALUSrcB = 00, ResultSrc = 11, Half = Instr[22], RegW. → FETCH.
- BRANCH: RegSrc[0] = 1, ALUSrcA = 00, ALUSrcB = 01, ResultSrc = 10, ADD, Branch. → FETCH.
- UNDEF: all enables 0 (NOP). → FETCH.
- RegSrc[1] = 1 when Op = 01 and Funct[0] = 0; RegSrc[0] = 1 when Op = 10. Both are combinational from Instr in every state.
- ALU decode (ALUOp = 1), by Funct[4:1]:
  - 0100 ADD; 0010 SUB; 1010 CMP (SUB); 1100 ORR
  - 0000 AND, or MUL / UMULL / SMULL when the MUL pattern is present
  - unlisted commands → ADD
- ALU decode (ALUOp = 0): ALUControl = ADD.
- FlagW (only when ALUOp = 1):
  - FlagW[1] = Funct[0] (forced to 1 for CMP)
  - FlagW[0] = FlagW[1] & (ADD | SUB | CMP)
  - otherwise FlagW = 00
- Output gating (combinational):
  - PCWrite = NextPC | (Branch & CondEx) | (RegW & CondEx & Rd == 15)
  - RegWrite = RegW & CondEx
  - RegWrite2 = RegW2 & CondEx
  - MemWrite = MemW & CondEx
- Failed condition: the FSM still walks the full path; only the gated enables are suppressed.
- Latencies in cycles: LDR 5, STR 4, data-processing 4, long multiply 4, FP 3, branch 3, undefined 3.

Decomposition:
- Package arm_ctrl_pkg:
  - state enum (4-bit)
  - ALUControl codes: ADD 0000, SUB 0001, AND 0010, ORR 0011, MUL 0100, UMULL 0101, SMULL 0110
  - ResultSrc, ALUSrcB and AdrSrc encodings
- Sub-module alu_decoder: combinational map from Funct, Instr[23:21], Instr[7:4] and ALUOp to ALUControl and FlagW.
- FSM register and output gating remain in mc_control_fsm.

Test Plan:
- Reset held 3 cycles mid-MEMWR → State = FETCH next edge; MemWrite = 0 throughout; first cycle after release shows IRWrite = 1, PCWrite = 1.
- Instr = 0xE5912004 (LDR, L = 1), CondEx = 1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite = 1 only in MEMWB with ResultSrc = 01; AdrSrc = 1 in MEMRD.
- Instr = 0xE0810392 (UMULL) → EXECR then MULWB; ALUControl = 0101; RegWrite = RegWrite2 = 1 in MULWB; total 4 cycles.
- Instr = 0xE0512003 (SUBS), CondEx = 1 → ALUWB with RegWrite = 1; FlagW = 11 in EXECR.
- Same instruction with CondEx = 0 → RegWrite = 0; states unchanged.
- Instr = 0xEE600000 (FP, Instr[22] = 1) → FPEXEC with ResultSrc = 11, Half = 1, RegWrite = 1; back in FETCH after 3 cycles.
- Instr = 0x0A000002 (BEQ) → BRANCH asserts PCWrite iff CondEx = 1, with RegSrc = 01; CondEx = 0 gives PCWrite = 0 in BRANCH.
